// File: rtl/seq_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen_if
// Bundles the host load handshake and the serial stream outputs of
// seq_pattern_gen.
//   load_valid / load_ready / load_data / load_len : host word load handshake
//   out / out_valid / out_last                     : serial bit stream, MSB first
//   busy                                           : generator is shifting a word
//   exp_match / match_cnt                          : reference 1011 tracker outputs
// Modports:
//   master : host / bench side (drives the load request, observes the stream)
//   slave  : generator side
// -----------------------------------------------------------------------------
interface seq_pattern_gen_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic [LEN_W-1:0]  load_len;
  logic              out;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              exp_match;
  logic [7:0]        match_cnt;

  modport master (
    output load_valid, load_data, load_len,
    input  load_ready, out, out_valid, out_last, busy, exp_match, match_cnt
  );

  modport slave (
    input  load_valid, load_data, load_len,
    output load_ready, out, out_valid, out_last, busy, exp_match, match_cnt
  );
endinterface : seq_pattern_gen_if

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
// Serial pattern generator. A host loads parallel words through a valid/ready
// handshake; each word is serialized MSB-first onto a one-bit stream intended to
// drive an overlapping Moore 1011 sequence detector. Words can be chained with
// no gap by offering the next word while the last bit of the current one is out.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : seq_pattern_gen_if.slave (load handshake, serial stream, tracker)
//
// Optional feature macro: SEQGEN_EXPECT_EN
//   defined   -> reference tracker drives exp_match (one-cycle pulse, Moore
//                timing) and an 8-bit saturating match_cnt
//   undefined -> no tracker logic; exp_match and match_cnt are tied to 0
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
  parameter int               DATA_W  = 16,
  parameter int               LEN_W   = 5,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_gen_if.slave   bus
);

  if ((2 ** LEN_W) <= DATA_W || PAT_W < 2) begin : g_param_check
    $error("seq_pattern_gen: need 2**LEN_W > DATA_W and PAT_W >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;      // current word, left-aligned; MSB is on the wire
  logic [LEN_W-1:0]  r_remaining;  // bits still to send, including the current one

  logic              w_load_ready;
  logic              w_accept;
  logic              w_out;
  logic              w_out_valid;
  logic              w_out_last;
  logic [LEN_W-1:0]  w_eff_len;
  logic [LEN_W-1:0]  w_align;

  // Length 0 and anything above DATA_W both mean a full-width word.
  assign w_eff_len = (bus.load_len == '0 || bus.load_len > FULL_LEN) ? FULL_LEN
                                                                     : bus.load_len;
  // Left-align the word so the first bit to send sits in the MSB; the stream
  // then only ever needs r_shift[DATA_W-1] and a plain left shift.
  assign w_align   = FULL_LEN - w_eff_len;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and stream outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_load_ready = 1'b0;
    w_out        = 1'b0;
    w_out_valid  = 1'b0;
    w_out_last   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_load_ready = 1'b1;
        if (bus.load_valid) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_out        = r_shift[DATA_W-1];
        w_out_valid  = 1'b1;
        w_out_last   = (r_remaining == LEN_W'(1));
        // A new word may only be taken while the last bit is out, which gives
        // gap-free chaining; otherwise the word ends and we go idle.
        w_load_ready = w_out_last;
        if (w_out_last && !bus.load_valid) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ready is held low while reset is asserted and rises once it is released.
  assign w_accept       = bus.load_valid && w_load_ready;
  assign bus.load_ready = w_load_ready && rst;
  assign bus.out        = w_out;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_last   = w_out_last;
  assign bus.busy       = (r_state == SHIFT);

  // ---------------------------------------------------------------------------
  // Word shifter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_shift     <= bus.load_data << w_align;
      r_remaining <= w_eff_len;
    end else if (r_state == SHIFT) begin
      r_shift     <= r_shift << 1;
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

`ifdef SEQGEN_EXPECT_EN
  // ---------------------------------------------------------------------------
  // Reference tracker: history of the last PAT_W stream bits. It only advances
  // on stream bits and survives gaps between words, so patterns spanning two
  // words are still seen. exp_match is registered, matching a Moore detector
  // whose output reflects the state entered on the edge the last bit was taken.
  // ---------------------------------------------------------------------------
  logic [PAT_W-1:0] r_hist;
  logic [PAT_W-1:0] w_hist_next;
  logic             w_hit;
  logic             r_exp_match;
  logic [7:0]       r_match_cnt;

  assign w_hist_next = {r_hist[PAT_W-2:0], w_out};
  assign w_hit       = w_out_valid && (w_hist_next == PATTERN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist      <= '0;
      r_exp_match <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      if (w_out_valid) begin
        r_hist <= w_hist_next;
      end
      r_exp_match <= w_hit;
      if (w_hit && r_match_cnt != 8'hFF) begin
        r_match_cnt <= r_match_cnt + 8'd1;
      end
    end
  end

  assign bus.exp_match = r_exp_match;
  assign bus.match_cnt = r_match_cnt;
`else
  logic w_unused_pattern;
  assign w_unused_pattern = ^PATTERN;
  assign bus.exp_match    = 1'b0;
  assign bus.match_cnt    = 8'd0;
`endif

endmodule : seq_pattern_gen

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern generator: the transmit-side counterpart of the team's 1011 Moore overlapping sequence detector. A host loads parallel words through a valid/ready handshake, and the block serializes them MSB-first onto a one-bit stream that feeds a detector's `in`. An optional built-in reference tracker flags where an overlapping Moore 1011 detector must assert, so benches can check detector output against it cycle by cycle.

## Interface
- `DATA_W`, 16: maximum word length in bits.
- `LEN_W`, 5: width of `load_len`; must satisfy 2^LEN_W > DATA_W.
- `PAT_W`, 4: tracked pattern length.
- `PATTERN`, 4'b1011: tracked pattern, MSB sent first.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `load_valid`  in  1  host offers a word.
- `load_ready`  out  1  block accepts a word this cycle.
- `load_data`  in  DATA_W  word; bits [len-1:0] are sent.
- `load_len`  in  LEN_W  bit count. 0 means DATA_W; values above DATA_W clamp to DATA_W.
- `out`  out  1  serial bit.
- `out_valid`  out  1  `out` carries a stream bit this cycle.
- `out_last`  out  1  current bit is the last bit of its word.
- `busy`  out  1  SHIFT state.
- `exp_match`  out  1  expected detector output (macro).
- `match_cnt`  out  8  saturating count of expected matches (macro).

## Operation
- States are IDLE and SHIFT.
  - IDLE: `load_ready`=1. On accept, the block latches the data, sets `remaining`=effective length, and goes to SHIFT.
  - SHIFT: `out` = data[remaining-1], `out_valid`=1, `out_last`=(remaining==1). Each cycle, `remaining` decrements.
  - In SHIFT, `load_ready`=`out_last`. If a word is accepted on the last bit, the block reloads and stays in SHIFT with no gap. If nothing is accepted, it returns to IDLE.
- A handshake occurs on a rising edge with `load_valid`&&`load_ready`. Data is ignored when `load_ready`=0, and the host must hold it.
- In IDLE, `out`=0, `out_valid`=0, `out_last`=0.
- Tracker: a PAT_W-bit history shift register.
  - It shifts in `out` on every edge where `out_valid`=1 and holds otherwise.
  - Stream gaps do not clear it. Only reset clears it.
  - Matches may overlap.
- `exp_match` is registered: it is 1 in the cycle after the edge on which the history equals PATTERN. This mirrors the Moore detector timing.
- `match_cnt` increments with each `exp_match` pulse and saturates at 255.

## Timing
- Reset (async assert, `rst`=0): state→IDLE, `remaining`=0, history=0, and all outputs→0 except `load_ready`. `load_ready` goes to 1 after reset is released.
- Reset asserted mid-word aborts the word immediately. The remaining bits are dropped, and the block does not generate `out_last` for the aborted word.
- Latency: the first bit is on `out` in the cycle after the accept edge.
- A word of length L occupies exactly L cycles of `out_valid`.
- Back-to-back words produce a continuous `out_valid`.
- `exp_match` asserts one cycle after the 4th bit of a PATTERN occurrence has been presented on `out`.
- Tracker history persists across word boundaries, so a pattern spanning two words is flagged.

## Configuration
- `SEQGEN_EXPECT_EN` defined: the tracker, `exp_match` and `match_cnt` are built as above.
- Not defined: no tracker logic is built. `exp_match` is tied 0 and `match_cnt` is tied 0, and the ports remain present.

## Test plan
- After reset, load 0xB with len 4 → `out` = 1,0,1,1 on 4 consecutive cycles. `out_last` is on the 4th bit. `exp_match`=1 in the following cycle, and `match_cnt`=1.
- Load 0x2DB with len 11 → stream 0,1,0,1,1,0,1,1,0,1,1. `exp_match` pulses 3 times, one cycle after the 5th, 8th and 11th bits, and `match_cnt`=3.
- Keep `load_valid` high with 0x5/len 3, then 0x1/len 1 → no gap in `out_valid`. `load_ready` is high only on the `out_last` cycles. The boundary-spanning 1011 gives `exp_match` one cycle after the 4th bit.
- Load 0x0000 with len 0 → 16 zero bits and `out_valid` for 16 cycles. No `exp_match`.
- Pull `rst` low during the 6th bit of a 16-bit word → `out_valid` and `out` go 0 immediately, and `match_cnt` goes to 0. After release, `load_ready`=1 and a new 0xB/len 4 transfer behaves as in the first scenario.
- Build without `SEQGEN_EXPECT_EN` and repeat the second scenario → identical `out` stream, with `exp_match` and `match_cnt` constant 0.
